// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: shared types and constants for the MIPS instruction encoder.
//   op_e    : 4-bit symbolic operation requested by the loader sequencer
//   state_e : output-register occupancy state of the encoder
//   OPC_* / FUNCT_* : MIPS major opcodes and R-type function codes
package instr_encoder_pkg;

    typedef enum logic [3:0] {
        OP_ADDU  = 4'd0,
        OP_SUBU  = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_SLTU  = 4'd4,
        OP_JR    = 4'd5,
        OP_LW    = 4'd6,
        OP_SW    = 4'd7,
        OP_BEQ   = 4'd8,
        OP_ADDIU = 4'd9,
        OP_J     = 4'd10,
        OP_JAL   = 4'd11,
        OP_LUI   = 4'd12,
        OP_ORI   = 4'd13,
        OP_BLTZ  = 4'd14,
        OP_LI    = 4'd15
    } op_e;

    localparam logic [5:0] OPC_SPECIAL = 6'b000000;
    localparam logic [5:0] OPC_REGIMM  = 6'b000001;
    localparam logic [5:0] OPC_J       = 6'b000010;
    localparam logic [5:0] OPC_JAL     = 6'b000011;
    localparam logic [5:0] OPC_BEQ     = 6'b000100;
    localparam logic [5:0] OPC_ADDIU   = 6'b001001;
    localparam logic [5:0] OPC_ORI     = 6'b001101;
    localparam logic [5:0] OPC_LUI     = 6'b001111;
    localparam logic [5:0] OPC_LW      = 6'b100011;
    localparam logic [5:0] OPC_SW      = 6'b101011;

    localparam logic [5:0] FUNCT_JR    = 6'b001000;
    localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
    localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_SLTU  = 6'b101011;

    // IDLE: output register empty; EMIT: one word held;
    // EMIT2: first word of an LI pair held, ORI word pending.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EMIT  = 2'd1,
        ST_EMIT2 = 2'd2
    } state_e;

endpackage

// File: rtl/instr_pack.sv
// instr_pack: combinational field packer, op + fields -> 32-bit MIPS word.
//   op_i     : operation (LI is not a machine op and packs to 0)
//   rs_i, rt_i, rd_i : register fields
//   imm_i    : 16-bit immediate for I-type ops
//   target_i : 26-bit jump target for J/JAL
//   word_o   : encoded instruction; fields unused by the op are 0
module instr_pack
    import instr_encoder_pkg::*;
(
    input  op_e         op_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [15:0] imm_i,
    input  logic [25:0] target_i,
    output logic [31:0] word_o
);

    always_comb begin
        word_o = '0;
        case (op_i)
            OP_ADDU:  word_o = {OPC_SPECIAL, rs_i, rt_i, rd_i, 5'd0, FUNCT_ADDU};
            OP_SUBU:  word_o = {OPC_SPECIAL, rs_i, rt_i, rd_i, 5'd0, FUNCT_SUBU};
            OP_AND:   word_o = {OPC_SPECIAL, rs_i, rt_i, rd_i, 5'd0, FUNCT_AND};
            OP_OR:    word_o = {OPC_SPECIAL, rs_i, rt_i, rd_i, 5'd0, FUNCT_OR};
            OP_SLTU:  word_o = {OPC_SPECIAL, rs_i, rt_i, rd_i, 5'd0, FUNCT_SLTU};
            OP_JR:    word_o = {OPC_SPECIAL, rs_i, 15'd0, FUNCT_JR};
            OP_LW:    word_o = {OPC_LW,    rs_i, rt_i, imm_i};
            OP_SW:    word_o = {OPC_SW,    rs_i, rt_i, imm_i};
            OP_BEQ:   word_o = {OPC_BEQ,   rs_i, rt_i, imm_i};
            OP_ADDIU: word_o = {OPC_ADDIU, rs_i, rt_i, imm_i};
            OP_ORI:   word_o = {OPC_ORI,   rs_i, rt_i, imm_i};
            OP_LUI:   word_o = {OPC_LUI,   5'd0, rt_i, imm_i};
            OP_BLTZ:  word_o = {OPC_REGIMM, rs_i, 5'd0, imm_i};
            OP_J:     word_o = {OPC_J,   target_i};
            OP_JAL:   word_o = {OPC_JAL, target_i};
            default:  word_o = '0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: sequential MIPS instruction encoder for the program loader.
// Accepts symbolic requests over valid/ready and emits addressed 32-bit words.
//   BASE_ADDR : byte address of the first emitted word
//   clk, reset (async, active-high), flush (sync: drop words, rewind address)
//   in_valid/in_ready, in_op, in_rs, in_rt, in_rd, in_imm, in_target : request
//   out_valid/out_ready, out_instr, out_addr : encoded word stream
//   err : one-cycle pulse after an illegal request is accepted
// Build option INSTR_ENCODER_PSEUDO_EN: when defined, LI (op 15) expands into
// ORI, LUI, or a LUI+ORI pair; when undefined, op 15 is illegal.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_imm,
    input  logic [25:0] in_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err
);

    state_e      state_q;
    logic [31:0] instr_q;
    logic [31:0] addr_q;
    logic        err_q;

    op_e         req_op;
    op_e         p_op;
    logic [4:0]  p_rs;
    logic [15:0] p_imm;
    logic        illegal;
    logic [31:0] first_word;
    logic        accept;
    logic        out_hs;

    assign req_op    = op_e'(in_op);
    assign out_valid = (state_q != ST_IDLE);
    assign out_instr = instr_q;
    assign out_addr  = addr_q;
    assign err       = err_q;
    // flush blocks acceptance; a pending ORI (EMIT2) blocks new requests.
    assign in_ready  = !flush && ((state_q == ST_IDLE) || ((state_q == ST_EMIT) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;

`ifdef INSTR_ENCODER_PSEUDO_EN
    logic        two_word;
    logic [31:0] ori_word;
    logic [31:0] ori_q;

    // LI chooses the cheapest form: ORI from $0, bare LUI, or LUI then ORI.
    always_comb begin
        p_op     = req_op;
        p_rs     = in_rs;
        p_imm    = in_imm[15:0];
        illegal  = 1'b0;
        two_word = 1'b0;
        if (req_op == OP_LI) begin
            if (in_imm[31:16] == 16'd0) begin
                p_op = OP_ORI;
                p_rs = 5'd0;
            end else begin
                p_op     = OP_LUI;
                p_imm    = in_imm[31:16];
                two_word = (in_imm[15:0] != 16'd0);
            end
        end
    end

    // Second word of a pair: ORI rt,rt,imm[15:0], captured at accept time.
    instr_pack u_pack_ori (
        .op_i     (OP_ORI),
        .rs_i     (in_rt),
        .rt_i     (in_rt),
        .rd_i     (5'd0),
        .imm_i    (in_imm[15:0]),
        .target_i (26'd0),
        .word_o   (ori_word)
    );
`else
    logic unused_imm_hi;
    assign unused_imm_hi = ^in_imm[31:16];

    always_comb begin
        p_op    = req_op;
        p_rs    = in_rs;
        p_imm   = in_imm[15:0];
        illegal = (req_op == OP_LI);
    end
`endif

    instr_pack u_pack_first (
        .op_i     (p_op),
        .rs_i     (p_rs),
        .rt_i     (in_rt),
        .rd_i     (in_rd),
        .imm_i    (p_imm),
        .target_i (in_target),
        .word_o   (first_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            instr_q <= '0;
            addr_q  <= BASE_ADDR;
            err_q   <= 1'b0;
`ifdef INSTR_ENCODER_PSEUDO_EN
            ori_q   <= '0;
`endif
        end else begin
            // accept is already gated by flush, so err cannot fire on a flush.
            err_q <= accept && illegal;
            if (flush) begin
                state_q <= ST_IDLE;
                addr_q  <= BASE_ADDR;
            end else begin
                if (out_hs) begin
                    addr_q <= addr_q + 32'd4;
                end
                if (accept) begin
                    // Accept only happens in IDLE or alongside an EMIT handshake,
                    // so the held word is free to be overwritten here.
                    if (illegal) begin
                        state_q <= ST_IDLE;
                    end else begin
                        instr_q <= first_word;
`ifdef INSTR_ENCODER_PSEUDO_EN
                        ori_q   <= ori_word;
                        state_q <= two_word ? ST_EMIT2 : ST_EMIT;
`else
                        state_q <= ST_EMIT;
`endif
                    end
                end else if (out_hs) begin
                    case (state_q)
`ifdef INSTR_ENCODER_PSEUDO_EN
                        ST_EMIT2: begin
                            instr_q <= ori_q;
                            state_q <= ST_EMIT;
                        end
`endif
                        default: state_q <= ST_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [31:0] in_imm;
    logic [25:0] in_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        err;

    instr_encoder #(.BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_imm(in_imm), .in_target(in_target),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
    } exp_t;

    exp_t        q[$];
    logic [31:0] next_addr = BASE;
    bit          exp_err = 1'b0;
    bit          acc = 1'b0;
    bit          fl = 1'b0;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference encoder built from opcode/funct tables and field shifts.
    function automatic logic [31:0] enc(input int op, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [15:0] imm,
                                        input logic [25:0] tgt);
        int opc_tab [16] = '{0, 0, 0, 0, 0, 0, 35, 43, 4, 9, 2, 3, 15, 13, 1, 0};
        int fn_tab  [6]  = '{33, 35, 36, 37, 43, 8};
        logic [31:0] w;
        w = 32'(opc_tab[op]) << 26;
        if (op <= 4)
            w = w | (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | 32'(fn_tab[op]);
        else if (op == 5)
            w = w | (32'(rs) << 21) | 32'(fn_tab[5]);
        else if (op == 10 || op == 11)
            w = w | 32'(tgt);
        else if (op == 12)
            w = w | (32'(rt) << 16) | 32'(imm);
        else if (op == 14)
            w = w | (32'(rs) << 21) | 32'(imm);
        else
            w = w | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
        return w;
    endfunction

    function automatic bit is_illegal(input int op);
`ifdef INSTR_ENCODER_PSEUDO_EN
        return 1'b0;
`else
        return op == 15;
`endif
    endfunction

    task automatic push_word(input logic [31:0] w);
        q.push_back('{instr: w, addr: next_addr});
        next_addr = next_addr + 32'd4;
    endtask

    task automatic push_req(input int op, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [31:0] imm, input logic [25:0] tgt);
        logic [15:0] hi, lo;
        hi = imm[31:16];
        lo = imm[15:0];
        if (is_illegal(op)) return;
        if (op == 15) begin
            if (hi == 16'd0) push_word(enc(13, 5'd0, rt, 5'd0, lo, 26'd0));
            else if (lo == 16'd0) push_word(enc(12, 5'd0, rt, 5'd0, hi, 26'd0));
            else begin
                push_word(enc(12, 5'd0, rt, 5'd0, hi, 26'd0));
                push_word(enc(13, rt, rt, 5'd0, lo, 26'd0));
            end
        end else begin
            push_word(enc(op, rs, rt, rd, imm[15:0], tgt));
        end
    endtask

    // Monitor: compares the DUT against the head of the expectation queue.
    always @(negedge clk) begin : monitor
        int n;
        n = q.size();
        chk("in_ready", in_ready, !flush && (n == 0 || (n == 1 && out_ready)));
        chk("out_valid", out_valid, n != 0);
        chk("err", err, exp_err);
        if (n != 0) begin
            chk("out_instr", out_instr, q[0].instr);
            chk("out_addr", out_addr, q[0].addr);
            if (out_ready && !flush && !reset) void'(q.pop_front());
        end
    end

    task automatic half_neg();
        @(negedge clk);
        acc = in_valid && in_ready;
        fl  = flush;
    endtask

    task automatic half_pos();
        @(posedge clk);
        #1;
        if (fl) begin
            q.delete();
            next_addr = BASE;
            exp_err   = 1'b0;
        end else begin
            exp_err = acc && is_illegal(int'(in_op));
            if (acc) push_req(int'(in_op), in_rs, in_rt, in_rd, in_imm, in_target);
        end
        acc = 1'b0;
    endtask

    task automatic cycle();
        half_neg();
        half_pos();
    endtask

    task automatic set_req(input int op, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [31:0] imm, input logic [25:0] tgt);
        in_valid  = 1'b1;
        in_op     = 4'(op);
        in_rs     = rs;
        in_rt     = rt;
        in_rd     = rd;
        in_imm    = imm;
        in_target = tgt;
    endtask

    task automatic do_flush();
        in_valid = 1'b0;
        flush    = 1'b1;
        cycle();
        flush    = 1'b0;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        flush     = 1'b0;
        reset     = 1'b1;
        q.delete();
        next_addr = BASE;
        exp_err   = 1'b0;
        half_neg();
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_addr", out_addr, BASE);
        half_pos();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_target = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", out_valid, 1'b0);
        chk("reset_instr", out_instr, 32'h0);
        chk("reset_addr", out_addr, BASE);
        chk("reset_err", err, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        half_neg();
        chk("ready_after_reset", in_ready, 1'b1);
        half_pos();

        // ADDU rd=3, rs=1, rt=2
        out_ready = 1'b1;
        set_req(0, 5'd1, 5'd2, 5'd3, 32'h0, 26'h0);
        cycle();
        in_valid = 1'b0;
        half_neg();
        chk("addu_word", out_instr, 32'h0022_1821);
        chk("addu_addr", out_addr, 32'h0);
        half_pos();
        half_neg();
        chk("addu_idle", out_valid, 1'b0);
        half_pos();

        // LW then JAL back-to-back
        do_flush();
        set_req(6, 5'd29, 5'd8, 5'd0, 32'h0000_0004, 26'h0);
        cycle();
        set_req(11, 5'd0, 5'd0, 5'd0, 32'h0, 26'h010_0000);
        half_neg();
        chk("lw_word", out_instr, 32'h8FA8_0004);
        chk("lw_addr", out_addr, 32'h0);
        half_pos();
        in_valid = 1'b0;
        half_neg();
        chk("jal_word", out_instr, 32'h0C10_0000);
        chk("jal_addr", out_addr, 32'h4);
        half_pos();
        cycle();

        // Output stall: word and address held, no new request accepted
        do_flush();
        out_ready = 1'b0;
        set_req(3, 5'd4, 5'd5, 5'd6, 32'h0, 26'h0);
        cycle();
        set_req(1, 5'd7, 5'd8, 5'd9, 32'h0, 26'h0);
        for (int i = 0; i < 3; i++) begin
            half_neg();
            chk("stall_word", out_instr, enc(3, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0));
            chk("stall_addr", out_addr, 32'h0);
            chk("stall_ready", in_ready, 1'b0);
            half_pos();
        end
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        repeat (2) cycle();

        // flush together with a valid request: not accepted
        set_req(2, 5'd1, 5'd1, 5'd1, 32'h0, 26'h0);
        flush = 1'b1;
        half_neg();
        chk("flush_ready", in_ready, 1'b0);
        half_pos();
        flush = 1'b0;
        in_valid = 1'b0;
        half_neg();
        chk("flush_novalid", out_valid, 1'b0);
        half_pos();

`ifdef INSTR_ENCODER_PSEUDO_EN
        // Two-word LI, with a request waiting behind it
        do_flush();
        set_req(15, 5'd0, 5'd9, 5'd0, 32'h1234_5678, 26'h0);
        cycle();
        set_req(0, 5'd1, 5'd2, 5'd3, 32'h0, 26'h0);
        half_neg();
        chk("li_hi_word", out_instr, 32'h3C09_1234);
        chk("li_hi_addr", out_addr, 32'h0);
        chk("li_emit2_ready", in_ready, 1'b0);
        half_pos();
        in_valid = 1'b0;
        half_neg();
        chk("li_lo_word", out_instr, 32'h3529_5678);
        chk("li_lo_addr", out_addr, 32'h4);
        half_pos();
        repeat (2) cycle();
        // Single-word LI
        do_flush();
        set_req(15, 5'd0, 5'd9, 5'd0, 32'h0000_0042, 26'h0);
        cycle();
        in_valid = 1'b0;
        half_neg();
        chk("li_small_word", out_instr, 32'h3409_0042);
        half_pos();
        cycle();
        // Reset after the first LI word is consumed: ORI word lost
        do_flush();
        set_req(15, 5'd0, 5'd9, 5'd0, 32'h1234_5678, 26'h0);
        cycle();
        in_valid = 1'b0;
        cycle();
        do_reset();
        half_neg();
        chk("li_reset_novalid", out_valid, 1'b0);
        half_pos();
`else
        // LI is illegal: err pulse, no word, address unchanged
        do_flush();
        set_req(0, 5'd1, 5'd2, 5'd3, 32'h0, 26'h0);
        cycle();
        set_req(15, 5'd0, 5'd9, 5'd0, 32'h1234_5678, 26'h0);
        cycle();
        in_valid = 1'b0;
        half_neg();
        chk("li_err", err, 1'b1);
        chk("li_novalid", out_valid, 1'b0);
        chk("li_addr_kept", out_addr, 32'h4);
        half_pos();
        half_neg();
        chk("li_err_pulse", err, 1'b0);
        half_pos();
        // Reset with a word held
        out_ready = 1'b0;
        set_req(9, 5'd3, 5'd4, 5'd0, 32'h0000_FFFF, 26'h0);
        cycle();
        do_reset();
        out_ready = 1'b1;
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int mode;
            logic [31:0] imm;
            imm  = $urandom;
            mode = $urandom_range(0, 3);
            if (mode == 1) imm[31:16] = 16'd0;
            if (mode == 2) imm[15:0] = 16'd0;
            set_req($urandom_range(0, 15), 5'($urandom), 5'($urandom), 5'($urandom), imm, 26'($urandom));
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            cycle();
            flush = 1'b0;
            if ($urandom_range(0, 299) == 0) do_reset();
        end

        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (6) cycle();
        chk("drain", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential MIPS instruction encoder, the inverse of the core's instruction decoder. It accepts symbolic instruction requests (operation plus register and immediate fields) over a valid/ready handshake. It emits 32-bit machine words, each with an incrementing byte address, for writing into instruction memory. It sits in the program-loader path between the test/boot sequencer and the instruction memory write port, and expands the LI pseudo-instruction into one or two words.

## Interface
- BASE_ADDR, 32'h0000_0000: byte address of the first emitted word.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous: drop the pending word(s) and rewind the address to BASE_ADDR.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_op  in  4  operation code: 0 ADDU, 1 SUBU, 2 AND, 3 OR, 4 SLTU, 5 JR, 6 LW, 7 SW, 8 BEQ, 9 ADDIU, 10 J, 11 JAL, 12 LUI, 13 ORI, 14 BLTZ, 15 LI.
- in_rs, in_rt, in_rd  in  5 each  register fields.
- in_imm  in  32  immediate; [15:0] is used for I-type ops, all 32 bits for LI.
- in_target  in  26  jump target for J and JAL.
- out_valid  out  1  word valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_instr  out  32  encoded instruction word.
- out_addr  out  32  byte address of out_instr.
- err  out  1  one-cycle pulse: the accepted request was illegal.

## Operation
- Encodings:
  - R-type uses opcode 000000, shamt 0, with funct ADDU 100001, SUBU 100011, AND 100100, OR 100101, SLTU 101011. JR is funct 001000 with rs only; rt and rd are 0.
  - I-type opcodes: LW 100011, SW 101011, BEQ 000100, ADDIU 001001, LUI 001111 (rs=0), ORI 001101, BLTZ 000001 (rt=0).
  - J-type: J 000010, JAL 000011, with {opcode, in_target}.
- Unused fields encode as 0.
- LI rt, imm32:
  - If imm[31:16]==0, emit the single word ORI rt,$0,imm[15:0].
  - Else if imm[15:0]==0, emit the single word LUI rt,imm[31:16].
  - Otherwise emit two words: LUI rt,imm[31:16], then ORI rt,rt,imm[15:0].
- State machine:
  - IDLE: output register empty.
  - EMIT: one word held.
  - EMIT2: the first word of a pair is held and the ORI word is pending.
- Transitions:
  - IDLE, on accept: go to EMIT, or to EMIT2 for a two-word LI.
  - EMIT, on output handshake: go to IDLE, or back to EMIT/EMIT2 if a new request is accepted in the same cycle.
  - EMIT2, on output handshake: load the ORI word and go to EMIT.
- in_ready = !flush && (state==IDLE || (state==EMIT && out_ready)). It is always low in EMIT2.
- out_addr advances by 4 on each output handshake and wraps modulo 2^32.
- An illegal request is accepted, pulses err in the next cycle, emits no word, and leaves out_addr unchanged.
- flush has priority over accept and over the output handshake in the same cycle. Next state is IDLE, out_valid=0, out_addr=BASE_ADDR.

## Timing
- Reset values: out_valid 0, out_instr 0, out_addr BASE_ADDR, err 0, state IDLE. in_ready reads 1 after reset is released.
- Latency: a request accepted at edge N is presented with out_valid=1 after edge N.
- The second LI word is presented in the cycle after the first word's handshake.
- Throughput: one word per cycle with out_ready held high. A two-word LI costs two cycles.
- While out_valid && !out_ready, out_instr and out_addr are held stable.
- Reset asserted mid-LI, in any state, returns to reset values immediately. The pending ORI word is lost.

## Configuration
- INSTR_ENCODER_PSEUDO_EN
  - Defined: LI (op 15) is expanded as described above.
  - Undefined: op 15 is illegal and produces an err pulse. The EMIT2 state and the ORI holding register are compiled out.

## Structure
- Package instr_encoder_pkg holds:
  - the 4-bit op enumeration;
  - the opcode and funct localparams;
  - the state typedef (IDLE, EMIT, EMIT2).
- Sub-module instr_pack: purely combinational mapping of (op, rs, rt, rd, imm16, target) to a 32-bit word. It is shared by the first and second word paths.

## Test plan
- ADDU rd=3, rs=1, rt=2, out_ready=1 -> out_instr 0x00221821 at out_addr 0x0, then IDLE.
- LW rt=8, rs=29, imm=0x0004, then JAL target=0x0100000 back-to-back -> 0x8FA80004 @0x0, then 0x0C100000 @0x4, on consecutive cycles.
- LI rt=9, imm=0x12345678 -> 0x3C091234 @0x0, then 0x35295678 @0x4, with in_ready low during EMIT2. LI rt=9, imm=0x00000042 -> single word 0x34090042.
- out_ready low for 3 cycles with a word held -> out_instr and out_addr stable, in_ready low. The word is consumed on release.
- reset after the first LI word is accepted by the consumer -> out_valid 0, out_addr BASE_ADDR, no ORI word emitted. flush with in_valid in the same cycle -> request not accepted.
- Macro undefined, LI request -> err=1 for exactly one cycle, no out_valid, out_addr unchanged.
